vec_alu_seq: RTL and testbench
==============================

# vec_alu_seq

Multi-cycle sequencer that runs scalar and vector ALU operations (add, sub, mul, vadd.fp, vmul.fp, vsum.fp, vset) on one shared single-lane FP/ALU unit. It sits between the execute stage and the shared functional unit (FU). It latches operands on `start`, issues one element at a time over a request/grant/result handshake, and assembles the result vector. While it runs it stalls the pipeline through `busy`.

## Interface
- `LANES`, default 4: vector element count, must be ≥ 2.
- `W`, default 32: element width in bits.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a new operation; sampled only in IDLE.
- `kill` in 1: synchronous abort; returns the block to IDLE.
- `alucontrol` in 3: operation code. 010 add, 110 sub, 000 mul, 011 vsum, 111 vset. All other codes are illegal.
- `vec` in 1: 1 = vector op (LANES elements), 0 = scalar op (lane 0 only).
- `srca` in LANES*W: operand A. Lane i is at bits [i*W +: W].
- `srcb` in LANES*W: operand B, same packing as `srca`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse, coincident with `done`, for an illegal code.
- `result` out LANES*W: result vector. Held stable from `done` until the next accepted `start`.
- `fu_req` out 1: operand-valid request to the FU.
- `fu_op` out 3: FU operation (010, 110 or 000).
- `fu_a` out W: FU operand A.
- `fu_b` out W: FU operand B.
- `fu_gnt` in 1: FU accepted the operands this cycle (valid while `fu_req` is high).
- `fu_rvalid` in 1: FU result valid.
- `fu_res` in W: FU result.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**, when `start`=1:
  - Latch `srca`, `srcb`, `alucontrol`, `vec`. Clear the result register to 0.
  - Illegal code, or 011 with `vec`=0 → DONE with `err`=1.
  - 111 → DONE without using the FU. `result` = lane 0 of `srca` broadcast to all lanes.
  - 011 (vsum) → acc = a[0], idx = 1, go to ISSUE.
  - Any other code → idx = 0, go to ISSUE.
- **ISSUE**: drive `fu_req`=1 and the operands below.
  - Element ops: `fu_a`=a[idx], `fu_b`=b[idx], `fu_op`=latched code.
  - vsum: `fu_a`=acc, `fu_b`=a[idx], `fu_op`=010.
  - Operands and `fu_op` stay constant until `fu_gnt`=1, then go to WAIT.
- **WAIT**: `fu_req`=0. On `fu_rvalid`=1:
  - Element ops write `fu_res` into result lane idx.
  - vsum writes `fu_res` into acc.
  - If idx is the last index, go to DONE. Otherwise idx+1 and go to ISSUE.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
  - For vsum, result lane 0 = acc and all other lanes = 0.
  - `err`, if flagged, pulses in this same cycle.
- Last index: LANES-1 when `vec`=1, 0 when `vec`=0. Scalar ops therefore issue exactly one FU op on lane 0, and lanes 1..LANES-1 of `result` are 0.
- Element count: vadd/vmul issue LANES FU ops; vsum issues LANES-1.
- Arithmetic is done entirely by the FU. The block does no rounding or width change; `fu_res` is stored verbatim.
- The FU has at most one operation outstanding at a time. `fu_rvalid` is ignored outside WAIT.
- `start` outside IDLE is ignored and not queued.
- `kill` in any state: go to IDLE next cycle, deassert `fu_req`, no `done`, `result` left as is. A grant in the same cycle as `kill` is abandoned, and its `fu_rvalid` is ignored.
- `kill` takes priority over `start`, `fu_gnt` and `fu_rvalid`.

## Timing
- Reset (`rst_n`=0, asynchronous) sets: state IDLE, `busy`=0, `done`=0, `err`=0, `fu_req`=0, `fu_op`=000, `fu_a`=0, `fu_b`=0, `result`=0, idx=0, acc=0.
- Reset mid-operation aborts immediately. Any later FU response is ignored.
- `start` is sampled at edge k; `busy` rises and the state is ISSUE (or DONE) from cycle k+1.
- Each element takes 1 + g + r cycles, where g = grant wait (≥0) and r = result wait (≥1).
- Zero-wait FU (`fu_gnt` tied high, `fu_rvalid` one cycle after grant):
  - vadd with LANES=4: `done` in cycle k+9.
  - vsum with LANES=4: `done` in cycle k+7.
  - Scalar op: `done` in cycle k+3.
  - vset or illegal code: `done` in cycle k+1.
- `busy` drops in the cycle after `done`. A new `start` is accepted from that cycle on.
- All outputs are registered or decoded directly from state. There is no combinational path from `fu_gnt` or `fu_rvalid` to `fu_req`.

## Test plan
- **vadd**: `vec`=1, code 010, a={1,2,3,4}, b={10,20,30,40}, FU echoes a+b → `result`={11,22,33,44}; 4 grants; `done` at k+9; `busy` high cycles k+1..k+9.
- **vsum**: `vec`=1, code 011, a={1,2,3,4}, FU adds → exactly 3 FU ops with `fu_a` sequence 1,3,6; `result`={10,0,0,0}.
- **Grant stall**: scalar code 110, `fu_gnt` held low 3 cycles → `fu_req`, `fu_a`, `fu_b`, `fu_op` stable for 4 cycles; `done` at k+6.
- **No-FU codes**: vset with a[0]=0x3F800000 → all lanes 0x3F800000, `done` at k+1, `fu_req` never asserted. Code 101 → `done`+`err` at k+1.
- **Abort**: `kill` in WAIT of element 2 → IDLE next cycle, no `done`, a late `fu_rvalid` ignored. A following vmul then completes correctly.
- **Reset mid-operation**: `rst_n` low in ISSUE → every output at its reset value asynchronously. A `start` arriving while `busy`=1 is ignored.

Source files
------------

// File: rtl/vec_alu_seq_if.sv
// Execute-stage request/result bundle plus the single-lane FU handshake for vec_alu_seq.
interface vec_alu_seq_if #(
  parameter int LANES = 4,
  parameter int W     = 32
);
  logic                 start;
  logic                 kill;
  logic [2:0]           alucontrol;
  logic                 vec;
  logic [LANES*W-1:0]   srca;
  logic [LANES*W-1:0]   srcb;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [LANES*W-1:0]   result;
  logic                 fu_req;
  logic [2:0]           fu_op;
  logic [W-1:0]         fu_a;
  logic [W-1:0]         fu_b;
  logic                 fu_gnt;
  logic                 fu_rvalid;
  logic [W-1:0]         fu_res;

  modport slave (
    input  start, kill, alucontrol, vec, srca, srcb, fu_gnt, fu_rvalid, fu_res,
    output busy, done, err, result, fu_req, fu_op, fu_a, fu_b
  );

  modport master (
    output start, kill, alucontrol, vec, srca, srcb, fu_gnt, fu_rvalid, fu_res,
    input  busy, done, err, result, fu_req, fu_op, fu_a, fu_b
  );
endinterface

// File: rtl/vec_alu_seq.sv
// Sequences scalar/vector ALU ops one element at a time through a shared FU
// and assembles the result vector; busy stalls the pipeline while running.
module vec_alu_seq #(
  parameter int LANES = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  vec_alu_seq_if.slave bus
);
  localparam int IW = $clog2(LANES);

  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_VSUM = 3'b011;
  localparam logic [2:0] OP_VSET = 3'b111;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [LANES*W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]         op_q, op_d, fu_op_q, fu_op_d;
  logic               vec_q, vec_d;
  logic [IW-1:0]      idx_q, idx_d, last_idx, nxt_idx;
  logic [W-1:0]       acc_q, acc_d, fu_a_q, fu_a_d, fu_b_q, fu_b_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d, fu_req_q, fu_req_d;
  logic               illegal;

  function automatic logic [W-1:0] lane_of(input logic [LANES*W-1:0] v, input logic [IW-1:0] i);
    return v[int'(i)*W +: W];
  endfunction

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    vec_d    = vec_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    fu_op_d  = fu_op_q;
    fu_a_d   = fu_a_q;
    fu_b_d   = fu_b_q;
    fu_req_d = fu_req_q;
    err_d    = 1'b0;
    last_idx = vec_q ? IW'(LANES-1) : '0;
    nxt_idx  = idx_q + IW'(1);
    illegal  = !(bus.alucontrol inside {OP_ADD, OP_SUB, OP_MUL, OP_VSUM, OP_VSET}) ||
               (bus.alucontrol == OP_VSUM && !bus.vec);

    if (bus.kill) begin
      // Abort leaves result/acc untouched; any in-flight FU response is dropped by IDLE.
      state_d  = IDLE;
      fu_req_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_d      = bus.srca;
            b_d      = bus.srcb;
            op_d     = bus.alucontrol;
            vec_d    = bus.vec;
            result_d = '0;
            if (illegal) begin
              state_d = DONE;
              err_d   = 1'b1;
            end else if (bus.alucontrol == OP_VSET) begin
              result_d = {LANES{bus.srca[W-1:0]}};
              state_d  = DONE;
            end else if (bus.alucontrol == OP_VSUM) begin
              acc_d    = bus.srca[W-1:0];
              idx_d    = IW'(1);
              fu_a_d   = bus.srca[W-1:0];
              fu_b_d   = bus.srca[W +: W];
              fu_op_d  = OP_ADD;
              fu_req_d = 1'b1;
              state_d  = ISSUE;
            end else begin
              idx_d    = '0;
              fu_a_d   = bus.srca[W-1:0];
              fu_b_d   = bus.srcb[W-1:0];
              fu_op_d  = bus.alucontrol;
              fu_req_d = 1'b1;
              state_d  = ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.fu_gnt) begin
            fu_req_d = 1'b0;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (bus.fu_rvalid) begin
            if (op_q == OP_VSUM) acc_d = bus.fu_res;
            else                 result_d[int'(idx_q)*W +: W] = bus.fu_res;
            if (idx_q == last_idx) begin
              if (op_q == OP_VSUM) result_d[W-1:0] = bus.fu_res;
              state_d = DONE;
            end else begin
              // Next operands are registered here so fu_a/fu_b never depend combinationally on the FU.
              idx_d    = nxt_idx;
              fu_req_d = 1'b1;
              state_d  = ISSUE;
              if (op_q == OP_VSUM) begin
                fu_a_d = bus.fu_res;
                fu_b_d = lane_of(a_q, nxt_idx);
              end else begin
                fu_a_d = lane_of(a_q, nxt_idx);
                fu_b_d = lane_of(b_q, nxt_idx);
              end
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      vec_q    <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      fu_op_q  <= '0;
      fu_a_q   <= '0;
      fu_b_q   <= '0;
      fu_req_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      vec_q    <= vec_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      fu_op_q  <= fu_op_d;
      fu_a_q   <= fu_a_d;
      fu_b_q   <= fu_b_d;
      fu_req_q <= fu_req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;
  assign bus.fu_req = fu_req_q;
  assign bus.fu_op  = fu_op_q;
  assign bus.fu_a   = fu_a_q;
  assign bus.fu_b   = fu_b_q;
endmodule

// File: tb/tb_vec_alu_seq.sv
// Bench for vec_alu_seq: FU model with programmable grant/result waits, a directed table,
// hand-written multi-cycle corner cases and randomized ops against a lane-level reference.
module tb_vec_alu_seq;
  localparam int LANES = 4;
  localparam int W     = 32;
  localparam int VW    = LANES*W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vec_alu_seq_if #(.LANES(LANES), .W(W)) bus();
  vec_alu_seq #(.LANES(LANES), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errs = 0;
  int checks = 0;
  int gnt_delay = 0;
  int rsp_delay = 1;
  int grants = 0;
  logic [W-1:0] fa_log[$];
  bit   fu_pend = 1'b0;
  int   fu_rcnt = 0;
  int   fu_gcnt = 0;
  logic [W-1:0] fu_pres = '0;

  typedef struct {
    string          name;
    logic [2:0]     op;
    logic           v;
    logic [VW-1:0]  a;
    logic [VW-1:0]  b;
    logic [VW-1:0]  res;
    logic           e;
    int             lat;
    int             nops;
  } vec_t;

  function automatic logic [VW-1:0] pk(input logic [W-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] x, y);
    case (op)
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b000:  return x * y;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Lane-level reference: what the finished result, error flag and FU op count must be.
  function automatic void ref_model(input logic [2:0] op, input logic v, input logic [VW-1:0] a, b,
                                    output logic [VW-1:0] r, output logic e, output int n);
    logic [W-1:0] sum;
    r = '0; e = 1'b0; n = 0;
    if (!(op inside {3'b010, 3'b110, 3'b000, 3'b011, 3'b111}) || (op == 3'b011 && !v)) begin
      e = 1'b1;
    end else if (op == 3'b111) begin
      for (int i = 0; i < LANES; i++) r[i*W +: W] = a[W-1:0];
    end else if (op == 3'b011) begin
      sum = '0;
      for (int i = 0; i < LANES; i++) sum = sum + a[i*W +: W];
      r[W-1:0] = sum;
      n = LANES - 1;
    end else begin
      n = v ? LANES : 1;
      for (int i = 0; i < n; i++) r[i*W +: W] = alu(op, a[i*W +: W], b[i*W +: W]);
    end
  endfunction

  function automatic vec_t mk(input string nm, input logic [2:0] op, input logic v,
                              input logic [VW-1:0] a, b, res, input logic e, input int lat, nops);
    vec_t t;
    t.name = nm; t.op = op; t.v = v; t.a = a; t.b = b; t.res = res; t.e = e; t.lat = lat; t.nops = nops;
    return t;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] ctl_outs();
    return VW'({bus.busy, bus.done, bus.err, bus.fu_req, bus.fu_op, bus.fu_a, bus.fu_b});
  endfunction

  // Shared FU model: grants after gnt_delay request cycles, answers rsp_delay cycles later.
  initial begin
    bus.fu_gnt = 1'b0; bus.fu_rvalid = 1'b0; bus.fu_res = '0;
    forever begin
      @(negedge clk);
      bus.fu_gnt = 1'b0; bus.fu_rvalid = 1'b0;
      if (!rst_n) begin
        fu_pend = 1'b0; fu_gcnt = 0;
      end else if (fu_pend) begin
        fu_rcnt--;
        if (fu_rcnt == 0) begin
          bus.fu_rvalid = 1'b1; bus.fu_res = fu_pres; fu_pend = 1'b0;
        end
      end else if (bus.fu_req) begin
        if (fu_gcnt >= gnt_delay) begin
          bus.fu_gnt = 1'b1; fu_pend = 1'b1; fu_rcnt = rsp_delay;
          fu_pres = alu(bus.fu_op, bus.fu_a, bus.fu_b);
          grants++; fa_log.push_back(bus.fu_a); fu_gcnt = 0;
        end else fu_gcnt++;
      end else fu_gcnt = 0;
    end
  end

  task automatic run_op(input logic [2:0] op, input logic v, input logic [VW-1:0] a, b, input int inj,
                        output int lat, output logic [VW-1:0] res, output logic e,
                        output int bc, output int rc, output bit stable, output int nops);
    int g0;
    bit prev_req;
    logic [2*W+2:0] prev;
    g0 = grants; prev_req = 1'b0; prev = '0;
    lat = -1; res = '0; e = 1'b0; bc = 0; rc = 0; stable = 1'b1;
    @(negedge clk); #1;
    bus.alucontrol = op; bus.vec = v; bus.srca = a; bus.srcb = b; bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0; bus.srca = rand_vec(); bus.srcb = rand_vec();
    bus.alucontrol = 3'($urandom); bus.vec = 1'($urandom);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (cyc > 1) begin @(negedge clk); #1; end
      bus.start = (cyc == inj);
      if (cyc == inj) bus.alucontrol = 3'b111;
      if (bus.busy) bc++;
      if (bus.fu_req) begin
        rc++;
        if (prev_req && {bus.fu_op, bus.fu_a, bus.fu_b} != prev) stable = 1'b0;
        prev = {bus.fu_op, bus.fu_a, bus.fu_b};
      end
      prev_req = bus.fu_req;
      if (bus.done) begin
        lat = cyc; res = bus.result; e = bus.err;
        break;
      end
    end
    bus.start = 1'b0;
    nops = grants - g0;
    @(negedge clk); #1;
    chk("busy_after_done", VW'(bus.busy), '0);
    chk("result_held", bus.result, res);
  endtask

  vec_t tbl[11];
  int lat, bc, rc, nops, en, exp_lat;
  bit stable, found, seen_done;
  logic [VW-1:0] res, er, ra, rb;
  logic e, ee, v;
  logic [2:0] op;
  logic [3*W-1:0] seq;

  initial begin
    bus.start = 1'b0; bus.kill = 1'b0; bus.alucontrol = '0; bus.vec = 1'b0;
    bus.srca = '0; bus.srcb = '0;

    tbl[0]  = mk("vadd",     3'b010, 1'b1, pk(1,2,3,4),  pk(10,20,30,40), pk(11,22,33,44), 1'b0, 9, 4);
    tbl[1]  = mk("vsum",     3'b011, 1'b1, pk(1,2,3,4),  pk(9,9,9,9),     pk(10,0,0,0),    1'b0, 7, 3);
    tbl[2]  = mk("sub_s",    3'b110, 1'b0, pk(100,5,5,5), pk(30,7,7,7),   pk(70,0,0,0),    1'b0, 3, 1);
    tbl[3]  = mk("mul_s",    3'b000, 1'b0, pk(6,9,9,9),  pk(7,9,9,9),     pk(42,0,0,0),    1'b0, 3, 1);
    tbl[4]  = mk("vmul",     3'b000, 1'b1, pk(2,3,4,5),  pk(10,10,10,10), pk(20,30,40,50), 1'b0, 9, 4);
    tbl[5]  = mk("vsub",     3'b110, 1'b1, pk(5,5,5,5),  pk(1,2,3,6),     pk(4,3,2,32'hFFFF_FFFF), 1'b0, 9, 4);
    tbl[6]  = mk("vset",     3'b111, 1'b1, pk(32'h3F80_0000,1,2,3), pk(8,8,8,8),
                 pk(32'h3F80_0000,32'h3F80_0000,32'h3F80_0000,32'h3F80_0000), 1'b0, 1, 0);
    tbl[7]  = mk("vset_s",   3'b111, 1'b0, pk(7,1,2,3),  pk(0,0,0,0),     pk(7,7,7,7),     1'b0, 1, 0);
    tbl[8]  = mk("ill_101",  3'b101, 1'b1, pk(1,2,3,4),  pk(1,2,3,4),     '0,              1'b1, 1, 0);
    tbl[9]  = mk("vsum_s",   3'b011, 1'b0, pk(1,2,3,4),  pk(1,2,3,4),     '0,              1'b1, 1, 0);
    tbl[10] = mk("ill_001",  3'b001, 1'b1, pk(1,2,3,4),  pk(1,2,3,4),     '0,              1'b1, 1, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", ctl_outs(), '0);
    chk("reset_result", bus.result, '0);
    rst_n = 1'b1;

    gnt_delay = 0; rsp_delay = 1;
    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].op, tbl[i].v, tbl[i].a, tbl[i].b, 0, lat, res, e, bc, rc, stable, nops);
      chk({tbl[i].name, "_result"}, res, tbl[i].res);
      chk({tbl[i].name, "_err"}, VW'(e), VW'(tbl[i].e));
      chk({tbl[i].name, "_latency"}, VW'(lat), VW'(tbl[i].lat));
      chk({tbl[i].name, "_fu_ops"}, VW'(nops), VW'(tbl[i].nops));
      chk({tbl[i].name, "_busy_cycles"}, VW'(bc), VW'(tbl[i].lat));
      if (tbl[i].nops == 0) chk({tbl[i].name, "_no_req"}, VW'(rc), '0);
    end

    // vsum accumulates through fu_a: 1, 1+2, 1+2+3.
    fa_log.delete();
    run_op(3'b011, 1'b1, pk(1,2,3,4), '0, 0, lat, res, e, bc, rc, stable, nops);
    chk("vsum_fa_count", VW'(fa_log.size()), VW'(3));
    seq = '0;
    foreach (fa_log[i]) if (i < 3) seq[i*W +: W] = fa_log[i];
    chk("vsum_fa_seq", VW'(seq), VW'({32'd6, 32'd3, 32'd1}));

    gnt_delay = 3;
    run_op(3'b110, 1'b0, pk(50,1,1,1), pk(8,1,1,1), 0, lat, res, e, bc, rc, stable, nops);
    chk("stall_latency", VW'(lat), VW'(6));
    chk("stall_req_cycles", VW'(rc), VW'(4));
    chk("stall_operands_stable", VW'(stable), VW'(1));
    chk("stall_result", res, pk(42,0,0,0));
    gnt_delay = 0;

    run_op(3'b010, 1'b1, pk(1,2,3,4), pk(10,20,30,40), 3, lat, res, e, bc, rc, stable, nops);
    chk("start_busy_result", res, pk(11,22,33,44));
    chk("start_busy_latency", VW'(lat), VW'(9));

    // Kill in WAIT of the second element; its late response must not land.
    rsp_delay = 4;
    begin
      int g0;
      g0 = grants; found = 1'b0; seen_done = 1'b0;
      @(negedge clk); #1;
      bus.alucontrol = 3'b010; bus.vec = 1'b1; bus.srca = pk(1,2,3,4); bus.srcb = pk(10,20,30,40);
      bus.start = 1'b1;
      @(negedge clk); #1;
      bus.start = 1'b0;
      for (int c = 0; c < 100; c++) begin
        if (grants == g0 + 2 && !bus.fu_req && bus.busy) begin found = 1'b1; break; end
        @(negedge clk); #1;
      end
      chk("kill_reached_wait", VW'(found), VW'(1));
      bus.kill = 1'b1;
      @(negedge clk); #1;
      bus.kill = 1'b0;
      chk("kill_idle", VW'({bus.busy, bus.done, bus.fu_req}), '0);
      chk("kill_result_kept", bus.result, pk(11,0,0,0));
      for (int c = 0; c < 6; c++) begin
        @(negedge clk); #1;
        if (bus.done || bus.busy) seen_done = 1'b1;
      end
      chk("kill_no_done", VW'(seen_done), '0);
      chk("kill_late_rvalid_ignored", bus.result, pk(11,0,0,0));
    end
    rsp_delay = 1;
    run_op(tbl[4].op, tbl[4].v, tbl[4].a, tbl[4].b, 0, lat, res, e, bc, rc, stable, nops);
    chk("after_kill_vmul_result", res, tbl[4].res);
    chk("after_kill_vmul_latency", VW'(lat), VW'(9));

    // Asynchronous reset while in ISSUE.
    gnt_delay = 5;
    @(negedge clk); #1;
    bus.alucontrol = 3'b010; bus.vec = 1'b1; bus.srca = pk(1,2,3,4); bus.srcb = pk(10,20,30,40);
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    chk("pre_reset_in_issue", VW'({bus.busy, bus.fu_req}), VW'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ctl", ctl_outs(), '0);
    chk("async_reset_result", bus.result, '0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    gnt_delay = 0;
    @(negedge clk); #1;
    chk("post_reset_idle", ctl_outs(), '0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      v  = 1'($urandom_range(0, 1));
      ra = rand_vec(); rb = rand_vec();
      gnt_delay = $urandom_range(0, 2);
      rsp_delay = $urandom_range(1, 3);
      ref_model(op, v, ra, rb, er, ee, en);
      exp_lat = (en == 0) ? 1 : 1 + en * (1 + gnt_delay + rsp_delay);
      run_op(op, v, ra, rb, 0, lat, res, e, bc, rc, stable, nops);
      chk($sformatf("rand%0d_op%0d_result", i, op), res, er);
      chk($sformatf("rand%0d_op%0d_err", i, op), VW'(e), VW'(ee));
      chk($sformatf("rand%0d_op%0d_latency", i, op), VW'(lat), VW'(exp_lat));
      chk($sformatf("rand%0d_op%0d_fu_ops", i, op), VW'(nops), VW'(en));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
